reg_write_arbiter: RTL

Round-robin write arbiter and sequencer for the register bank's shared write port. Up to P_Requesters masters post write requests (address + data). The block grants one at a time and drives the address/enable pair of the register bank's address decoder together with the write data for exactly one cycle. It then acknowledges the winner. It sits between the datapath masters and the decoder/register bank, and is the only block allowed to drive the decoder enable.

---
 rtl/reg_write_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that serialises master write requests onto the register
// bank's single write port: one grant, one enable strobe, then one done pulse.
module reg_write_arbiter #(
  parameter int P_RegCount   = 8,
  parameter int P_DataWidth  = 8,
  parameter int P_Requesters = 4,
  localparam int AW = $clog2(P_RegCount),
  localparam int IW = $clog2(P_Requesters)
) (
  input  logic                              In_Clock,
  input  logic                              In_Reset,
  input  logic [P_Requesters-1:0]           In_Request,
  input  logic [P_Requesters*AW-1:0]        In_Address,
  input  logic [P_Requesters*P_DataWidth-1:0] In_Data,
  output logic [P_Requesters-1:0]           Out_Grant,
  output logic [AW-1:0]                     Out_Address,
  output logic                              Out_Enable,
  output logic [P_DataWidth-1:0]            Out_Data,
  output logic [P_Requesters-1:0]           Out_Done,
  output logic                              Out_Error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [IW-1:0]             r_ptr;
  logic [IW-1:0]             r_owner;
  logic [P_Requesters-1:0]   r_grant;
  logic [AW-1:0]             r_addr;
  logic [P_DataWidth-1:0]    r_data;
  logic                      r_enable;
  logic [P_Requesters-1:0]   r_done;
  logic                      r_error;
  logic                      r_err_flag;

  logic                      w_found;
  logic [IW-1:0]             w_sel;
  logic [IW:0]               w_idx;
  logic [AW-1:0]             w_sel_addr;
  logic                      w_in_range;
  logic [IW-1:0]             w_ptr_next;

  // Scan requesters starting at the pointer, wrapping, and take the first hit.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < P_Requesters; k++) begin
      w_idx = (IW+1)'(r_ptr) + (IW+1)'(k);
      if (w_idx >= (IW+1)'(P_Requesters))
        w_idx = w_idx - (IW+1)'(P_Requesters);
      if (!w_found && In_Request[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[IW-1:0];
      end
    end
  end

  assign w_sel_addr = In_Address[w_sel*AW +: AW];
  assign w_in_range = ({1'b0, w_sel_addr} < (AW+1)'(P_RegCount));
  assign w_ptr_next = (r_owner == IW'(P_Requesters - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge In_Clock or posedge In_Reset) begin
    if (In_Reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_enable   <= 1'b0;
      r_done     <= '0;
      r_error    <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner    <= w_sel;
            r_grant    <= P_Requesters'(1) << w_sel;
            r_addr     <= w_sel_addr;
            r_data     <= In_Data[w_sel*P_DataWidth +: P_DataWidth];
            // Strobe is raised on entry to WRITE so it is visible for that one cycle.
            r_enable   <= w_in_range;
            r_err_flag <= ~w_in_range;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_enable <= 1'b0;
          r_done   <= r_grant;
          r_error  <= r_err_flag;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done     <= '0;
          r_error    <= 1'b0;
          r_grant    <= '0;
          r_err_flag <= 1'b0;
          r_ptr      <= w_ptr_next;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_enable <= 1'b0;
          r_done   <= '0;
          r_error  <= 1'b0;
          r_grant  <= '0;
        end
      endcase
    end
  end

  assign Out_Grant   = r_grant;
  assign Out_Address = r_addr;
  assign Out_Enable  = r_enable;
  assign Out_Data    = r_data;
  assign Out_Done    = r_done;
  assign Out_Error   = r_error;

endmodule
